// File: rtl/isa_pkg.sv
// Shared encodings for the 19-bit multi-cycle core: opcodes, FSM states,
// write-back and ALU selects, instruction field positions and the decoded-IR bundle.
package isa_pkg;

    localparam int OP_MSB = 18, OP_LSB = 15;
    localparam int F1_MSB = 14, F1_LSB = 10;
    localparam int F2_MSB = 9,  F2_LSB = 5;
    localparam int F3_MSB = 4,  F3_LSB = 0;
    localparam int IMM_MSB = 9, IMM_LSB = 0;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_MUL2 = 4'b0011;
    localparam logic [3:0] OP_BNEZ = 4'b0100;
    localparam logic [3:0] OP_MV   = 4'b0101;
    localparam logic [3:0] OP_LD   = 4'b0110;
    localparam logic [3:0] OP_ST   = 4'b0111;
    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_STI  = 4'b1001;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;
    localparam logic [1:0] WB_RS1 = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_XOR  = 2'b10;
    localparam logic [1:0] ALU_MUL2 = 2'b11;

    typedef struct packed {
        logic [F1_MSB-F1_LSB:0]   f1;
        logic [F2_MSB-F2_LSB:0]   f2;
        logic [F3_MSB-F3_LSB:0]   f3;
        logic [IMM_MSB-IMM_LSB:0] imm;
        logic [F3_MSB-F3_LSB:0]   waddr;
        logic [1:0]               wb_sel;
        logic [1:0]               alu_ctrl;
        logic                     is_write;
        logic                     is_branch;
        logic                     is_mem;
        logic                     is_load;
        logic                     mem_we;
        logic                     addr_imm;
        logic                     illegal;
    } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: splits the IR into fields and derives the
// per-opcode control flags consumed by the sequencer.
module ctrl_decode
    import isa_pkg::*;
(
    input  logic [OP_MSB:0] ir,
    output dec_t            dec
);

    always_comb begin
        dec          = '0;
        dec.f1       = ir[F1_MSB:F1_LSB];
        dec.f2       = ir[F2_MSB:F2_LSB];
        dec.f3       = ir[F3_MSB:F3_LSB];
        dec.imm      = ir[IMM_MSB:IMM_LSB];
        dec.waddr    = ir[F3_MSB:F3_LSB];
        dec.wb_sel   = WB_ALU;
        dec.alu_ctrl = ALU_ADD;
        case (ir[OP_MSB:OP_LSB])
            OP_ADD, OP_SUB, OP_XOR, OP_MUL2: begin
                dec.is_write = 1'b1;
                // ALU opcodes are numbered in the same order as the alu_ctrl encoding
                dec.alu_ctrl = ir[OP_LSB+1:OP_LSB];
            end
            OP_BNEZ: dec.is_branch = 1'b1;
            OP_MV: begin
                dec.is_write = 1'b1;
                dec.wb_sel   = WB_RS1;
            end
            OP_LD: begin
                dec.is_mem  = 1'b1;
                dec.is_load = 1'b1;
                dec.wb_sel  = WB_MEM;
            end
            OP_ST: begin
                dec.is_mem = 1'b1;
                dec.mem_we = 1'b1;
            end
            OP_LDI: begin
                dec.is_write = 1'b1;
                dec.wb_sel   = WB_IMM;
                dec.waddr    = ir[F1_MSB:F1_LSB];
            end
            OP_STI: begin
                dec.is_mem   = 1'b1;
                dec.mem_we   = 1'b1;
                dec.addr_imm = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: owns PC and IR, fetches over a req/ready handshake and
// steps FETCH/DECODE/EXEC/MEM/WB, parking in HALT on undefined opcodes.
module multicycle_ctrl
    import isa_pkg::*;
#(
    parameter int              INST_W   = 19,
    parameter int              PC_W     = 10,
    parameter int              REG_AW   = 5,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    output logic [REG_AW-1:0] rf_raddr3,
    input  logic              rs1_is_zero,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [1:0]        wb_sel,
    output logic [1:0]        alu_ctrl,
    output logic [9:0]        imm,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              dmem_addr_sel,
    input  logic              dmem_ready,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              halted
);

    state_t            state, state_n;
    logic [INST_W-1:0] ir;
    logic [PC_W-1:0]   pc_n, pc_inc;
    logic              ir_ld;
    dec_t              dec;

    ctrl_decode u_dec (.ir(ir), .dec(dec));

    assign pc_inc    = pc + PC_W'(1);
    assign imem_addr = pc;
    assign rf_raddr1 = dec.f1;
    assign rf_raddr2 = dec.f2;
    assign rf_raddr3 = dec.f3;
    assign rf_waddr  = dec.waddr;
    assign imm       = dec.imm;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (ir_ld) ir <= imem_rdata;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        ir_ld         = 1'b0;
        imem_req      = 1'b0;
        rf_we         = 1'b0;
        wb_sel        = WB_ALU;
        alu_ctrl      = ALU_ADD;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr_sel = 1'b0;
        retire        = 1'b0;
        halted        = 1'b0;
        // outputs stay quiet while reset is held, whatever state is still registered
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_ld   = 1'b1;
                        state_n = S_DECODE;
                    end
                end
                S_DECODE: state_n = dec.illegal ? S_HALT : S_EXEC;
                S_EXEC: begin
                    if (dec.is_mem) begin
                        state_n = S_MEM;
                    end else begin
                        rf_we    = dec.is_write;
                        wb_sel   = dec.wb_sel;
                        alu_ctrl = dec.alu_ctrl;
                        retire   = 1'b1;
                        pc_n     = (dec.is_branch && !rs1_is_zero) ? dec.imm[PC_W-1:0] : pc_inc;
                        state_n  = S_FETCH;
                    end
                end
                S_MEM: begin
                    dmem_req      = 1'b1;
                    dmem_we       = dec.mem_we;
                    dmem_addr_sel = dec.addr_imm;
                    if (dmem_ready) begin
                        if (dec.is_load) begin
                            state_n = S_WB;
                        end else begin
                            retire  = 1'b1;
                            pc_n    = pc_inc;
                            state_n = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    rf_we   = 1'b1;
                    wb_sel  = WB_MEM;
                    retire  = 1'b1;
                    pc_n    = pc_inc;
                    state_n = S_FETCH;
                end
                S_HALT:  halted = 1'b1;
                default: state_n = S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a stimulus process plays imem/dmem and pushes
// expected effects into queues; a monitor pops and compares whenever the DUT acts.
module tb_multicycle_ctrl;

    logic        clk = 1'b0, reset = 1'b1;
    logic        imem_req, imem_ready = 1'b0;
    logic [9:0]  imem_addr, pc, imm;
    logic [18:0] imem_rdata = '0;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_raddr3, rf_waddr;
    logic        rs1_is_zero = 1'b0, rf_we, dmem_req, dmem_we, dmem_addr_sel;
    logic        dmem_ready = 1'b0, retire, halted;
    logic [1:0]  wb_sel, alu_ctrl;

    multicycle_ctrl #(.INST_W(19), .PC_W(10), .REG_AW(5), .RESET_PC(10'd0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_raddr3(rf_raddr3),
        .rs1_is_zero(rs1_is_zero), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .wb_sel(wb_sel), .alu_ctrl(alu_ctrl), .imm(imm),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr_sel(dmem_addr_sel), .dmem_ready(dmem_ready),
        .pc(pc), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [4:0] wa;
        logic [1:0] ws;
        logic [1:0] ac;
        logic       mem;
        logic       mwe;
        logic       msel;
        logic       ill;
        logic [4:0] f1, f2, f3;
        logic [9:0] imm;
        logic [9:0] npc;
        logic [7:0] lat;
    } exp_t;

    exp_t       q_ret[$], q_wr[$], q_mem[$];
    logic [9:0] q_addr[$];
    logic [9:0] mpc = '0;
    int total = 0, bad = 0, cyc = 0, hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Reference: what one instruction must do, straight from the opcode table.
    // lat = cycles from the fetch-handshake cycle to the retire cycle.
    function automatic exp_t model(input logic [9:0] cur_pc, input logic [18:0] i, input bit z, input int k);
        exp_t e;
        logic [3:0] op;
        e     = '0;
        op    = i[18:15];
        e.f1  = i[14:10];
        e.f2  = i[9:5];
        e.f3  = i[4:0];
        e.imm = i[9:0];
        e.npc = cur_pc + 10'd1;
        e.lat = 8'd2;
        case (op)
            4'd0: begin e.wr = 1; e.wa = e.f3; e.ws = 2'b00; e.ac = 2'b00; end
            4'd1: begin e.wr = 1; e.wa = e.f3; e.ws = 2'b00; e.ac = 2'b01; end
            4'd2: begin e.wr = 1; e.wa = e.f3; e.ws = 2'b00; e.ac = 2'b10; end
            4'd3: begin e.wr = 1; e.wa = e.f3; e.ws = 2'b00; e.ac = 2'b11; end
            4'd4: if (!z) e.npc = e.imm;
            4'd5: begin e.wr = 1; e.wa = e.f3; e.ws = 2'b11; end
            4'd8: begin e.wr = 1; e.wa = e.f1; e.ws = 2'b10; end
            4'd6: begin e.mem = 1; e.wr = 1; e.wa = e.f3; e.ws = 2'b01; e.lat = 8'(4 + k); end
            4'd7: begin e.mem = 1; e.mwe = 1; e.lat = 8'(3 + k); end
            4'd9: begin e.mem = 1; e.mwe = 1; e.msel = 1; e.lat = 8'(3 + k); end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    task automatic dmem_resp(input int k);
        int n = 0;
        while (!dmem_req && n < 20) begin
            imem_ready = 1'($urandom); imem_rdata = 19'($urandom);
            @(posedge clk); #1; n++;
        end
        if (!dmem_req) begin imem_ready = 0; chk("dmem_req_timeout", 0, 1); return; end
        repeat (k) begin
            imem_ready = 1'($urandom); imem_rdata = 19'($urandom);
            @(posedge clk); #1;
        end
        imem_ready = 0; dmem_ready = 1;
        @(posedge clk); #1;
        dmem_ready = 0;
    endtask

    // k < 0: leave the memory access hanging (caller deals with it)
    task automatic issue(input logic [18:0] insn, input bit z, input int idly, input int k);
        int   n = 0;
        exp_t e;
        while (!imem_req && n < 60) begin
            dmem_ready = 1'($urandom);
            @(posedge clk); #1; n++;
        end
        if (!imem_req) begin dmem_ready = 0; chk("imem_req_timeout", 0, 1); return; end
        repeat (idly) begin dmem_ready = 1'($urandom); @(posedge clk); #1; end
        dmem_ready = 0;
        e = model(mpc, insn, z, k);
        if (!e.ill) begin
            q_ret.push_back(e);
            q_addr.push_back(e.npc);
            if (e.wr)  q_wr.push_back(e);
            if (e.mem) q_mem.push_back(e);
            mpc = e.npc;
        end
        imem_rdata = insn; imem_ready = 1; rs1_is_zero = z;
        @(posedge clk); #1;
        imem_ready = 0; imem_rdata = 19'($urandom);
        if (e.mem && k >= 0) dmem_resp(k);
    endtask

    task automatic restart();
        q_ret.delete(); q_wr.delete(); q_mem.delete(); q_addr.delete();
        q_addr.push_back(10'd0);
        mpc = 10'd0;
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (imem_req && imem_ready) begin
                    hs_cyc = cyc;
                    if (q_addr.size() == 0) chk("fetch_unexpected", 1, 0);
                    else chk("fetch_addr", 32'(imem_addr), 32'(q_addr.pop_front()));
                end
                if (rf_we) begin
                    chk("we_with_retire", 32'(retire), 1);
                    if (q_wr.size() == 0) chk("rf_we_unexpected", 1, 0);
                    else begin
                        e = q_wr.pop_front();
                        chk("rf_waddr", 32'(rf_waddr), 32'(e.wa));
                        chk("wb_sel", 32'(wb_sel), 32'(e.ws));
                        if (e.ws == 2'b00) chk("alu_ctrl", 32'(alu_ctrl), 32'(e.ac));
                    end
                end
                if (dmem_req) begin
                    if (q_mem.size() == 0) chk("dmem_unexpected", 1, 0);
                    else begin
                        e = q_mem[0];
                        chk("dmem_we", 32'(dmem_we), 32'(e.mwe));
                        chk("dmem_addr_sel", 32'(dmem_addr_sel), 32'(e.msel));
                        chk("mem_alu_add", 32'(alu_ctrl), 0);
                        chk("mem_imm", 32'(imm), 32'(e.imm));
                        chk("mem_raddr1", 32'(rf_raddr1), 32'(e.f1));
                        if (dmem_ready) void'(q_mem.pop_front());
                    end
                end
                if (retire) begin
                    if (q_ret.size() == 0) chk("retire_unexpected", 1, 0);
                    else begin
                        e = q_ret.pop_front();
                        chk("latency", 32'(cyc - hs_cyc), 32'(e.lat));
                        chk("raddr1", 32'(rf_raddr1), 32'(e.f1));
                        chk("raddr2", 32'(rf_raddr2), 32'(e.f2));
                        chk("raddr3", 32'(rf_raddr3), 32'(e.f3));
                        chk("imm", 32'(imm), 32'(e.imm));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_dmem_req", 32'(dmem_req), 0);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_retire", 32'(retire), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_pc", 32'(pc), 0);
        @(posedge clk); #1;
        reset = 0;
        restart();

        issue(19'b0000_00001_00010_00011, 0, 0, 0);       // add r1,r2->r3
        issue({4'd4, 5'd4, 10'h3FF}, 0, 0, 0);             // bnez taken -> 1023
        issue({4'd0, 5'd1, 5'd1, 5'd1}, 0, 1, 0);          // sequential, pc wraps to 0
        issue({4'd4, 5'd4, 10'h3FF}, 1, 0, 0);             // bnez not taken
        issue({4'd6, 5'd1, 5'd2, 5'd5}, 0, 0, 3);          // ld, ready after 3 waits
        issue({4'd9, 5'd7, 10'h055}, 0, 0, 0);             // sti r7,0x055
        issue({4'd8, 5'd9, 10'h2AB}, 0, 2, 0);             // ldi
        issue({4'd5, 5'd3, 5'd0, 5'd6}, 0, 0, 0);          // mv
        issue({4'd7, 5'd3, 5'd4, 5'd5}, 0, 0, 2);          // st
        for (int i = 0; i < 150; i++)
            issue({4'($urandom_range(0, 9)), 15'($urandom)}, 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        repeat (6) @(posedge clk);
        #1;

        // reset while waiting on data memory
        issue({4'd7, 5'd3, 5'd4, 5'd5}, 0, 0, -1);
        n = 0;
        while (!dmem_req && n < 10) begin @(posedge clk); #1; n++; end
        repeat (2) @(posedge clk);
        #1;
        chk("mem_wait_req", 32'(dmem_req), 1);
        reset = 1;
        restart();
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("mrst_dmem_req", 32'(dmem_req), 0);
        chk("mrst_pc", 32'(pc), 0);
        chk("mrst_retire", 32'(retire), 0);
        chk("mrst_imem_req", 32'(imem_req), 1);
        @(posedge clk); #1;
        issue({4'd1, 5'd2, 5'd3, 5'd4}, 0, 0, 0);

        // undefined opcode parks the core
        issue({4'b1100, 15'($urandom)}, 0, 0, 0);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_flag", 32'(halted), 1);
            chk("halt_quiet", 32'({imem_req, dmem_req, rf_we, retire, dmem_we}), 0);
            imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        end
        imem_ready = 0; dmem_ready = 0;
        @(posedge clk); #1;
        reset = 1;
        restart();
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("hrst_pc", 32'(pc), 0);
        chk("hrst_halted", 32'(halted), 0);
        chk("hrst_imem_req", 32'(imem_req), 1);
        @(posedge clk); #1;
        issue(19'b0000_00001_00010_00011, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            issue({4'($urandom_range(0, 9)), 15'($urandom)}, 1'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 2));
        repeat (6) @(posedge clk);
        @(negedge clk);

        chk("drain_ret", q_ret.size(), 0);
        chk("drain_wr", q_wr.size(), 0);
        chk("drain_mem", q_mem.size(), 0);
        chk("drain_addr", q_addr.size(), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the 19-bit, 4-bit-opcode processor. It owns the PC and the instruction register, and fetches from instruction memory over a req/ready handshake. It sequences register-file reads/writes, ALU control, and data-memory accesses for opcodes 0000-1001. Any undefined opcode parks the core in HALT. Sits between instruction memory, the register file/ALU datapath and data memory.

Parameters:
INST_W, 19, instruction width ([18:15] opcode, [14:10] f1, [9:5] f2, [4:0] f3, [9:0] imm10)
PC_W, 10, PC / branch-target width
REG_AW, 5, register address width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ready  in  1  imem_rdata valid this cycle
imem_rdata  in  INST_W  fetched instruction
rf_raddr1/rf_raddr2/rf_raddr3  out  REG_AW  register read addresses
rs1_is_zero  in  1  datapath flag: rf read port 1 data == 0
rf_we  out  1  register write enable (single-cycle pulse)
rf_waddr  out  REG_AW  write address
wb_sel  out  2  00 ALU, 01 MEM, 10 IMM, 11 RS1
alu_ctrl  out  2  00 add, 01 sub, 10 xor, 11 mul2 (bit0=ALUcontrol1, bit1=ALUcontrol2)
imm  out  10  imm10 of current IR
dmem_req  out  1  data memory request
dmem_we  out  1  1 store, 0 load (valid with dmem_req)
dmem_addr_sel  out  1  0 ALU result (rs1+rs2), 1 imm
dmem_ready  in  1  access complete / load data valid
pc  out  PC_W  current PC
retire  out  1  one-cycle pulse when an instruction completes
halted  out  1  high in HALT

Behaviour:
- Reset: all outputs 0, pc=RESET_PC, IR=0, state FETCH. Reset is synchronous and active-high and overrides any in-flight handshake; dmem_req/imem_req drop on the cycle after reset is sampled.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1 and held until imem_ready. On the ready cycle, IR<=imem_rdata, then go to DECODE. No timeout.
- DECODE: drive rf_raddr1=f1, raddr2=f2, raddr3=f3. Opcode >1001 goes to HALT with no write and no retire. Otherwise go to EXEC.
- Read addresses and imm stay stable from DECODE until the next FETCH.
- EXEC by opcode:
  - add/sub/xor/mul2 (0000-0011): rf_we=1, waddr=f3, wb_sel=ALU, alu_ctrl as encoded.
  - mv (0101): rf_we, waddr=f3, wb_sel=RS1.
  - ldi (1000): rf_we, waddr=f1, wb_sel=IMM.
  - bnez (0100): if !rs1_is_zero then pc<=imm10[PC_W-1:0], else pc<=pc+1.
  - All of the above retire in EXEC and return to FETCH.
  - ld (0110): alu_ctrl=add, go to MEM.
  - st (0111): alu_ctrl=add, go to MEM.
  - sti (1001): go to MEM.
- MEM: dmem_req=1, held until dmem_ready.
  - Sources: ld addr=rs1+rs2; st addr=rs1+rs2, data=rs3; sti addr=imm10, data=rs1.
  - dmem_we=1 for st/sti; dmem_addr_sel=1 only for sti; alu_ctrl held at add.
  - On dmem_ready: ld goes to WB. st/sti retire and go to FETCH with pc+1.
- WB (ld only): rf_we=1, waddr=f3, wb_sel=MEM, retire, pc+1, go to FETCH.
- Minimum latency with ready=1 immediately: ALU/mv/ldi/bnez 3 cycles; st/sti 4 cycles; ld 5 cycles.
- pc+1 wraps 1023 -> 0. A branch target is used unmodified.
- HALT: all req/we outputs 0, halted=1. Exits only via reset.
- imem_ready outside FETCH and dmem_ready outside MEM are ignored.
- rf_we is never asserted in FETCH, DECODE, MEM or HALT.

Decomposition:
- Package isa_pkg: opcode localparams OP_ADD..OP_STI, state enum, WB_* and ALU_* encodings, field bit positions.
- Sub-module ctrl_decode (combinational): IR -> field extraction, is_mem/is_write/wb_sel/alu_ctrl/illegal flags.
- multicycle_ctrl keeps the FSM, PC and IR.

Test Plan:
- Reset, then "add r1,r2->r3" (0000_00001_00010_00011), imem_ready=1 -> rf_we at cycle 3, waddr=3, alu_ctrl=00, wb_sel=00, retire, pc=1.
- bnez r4,0x3FF: rs1_is_zero=0 -> pc=1023; next insn sequential -> pc wraps to 0. With rs1_is_zero=1 -> pc=pc+1, rf_we never high.
- ld r1,r2->r5 with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then 1-cycle rf_we waddr=5 wb_sel=01; total 8 cycles.
- sti r7,0x055 -> dmem_req, dmem_we=1, dmem_addr_sel=1, imm=0x055, raddr1=7; no rf_we; retire on ready.
- Opcode 1100 -> halted=1 after DECODE, no req/we thereafter for 20 cycles; reset -> pc=0, FETCH resumes.
- Reset asserted during MEM wait -> dmem_req=0 on the next cycle, pc=RESET_PC, no retire.
